// File: rtl/dqpsk_pkg.sv
// Shared DQPSK modem definitions: symbol width, bit-clock rate and symbol type.
package dqpsk_pkg;

    localparam int SYM_BITS   = 2;
    localparam int BIT_CLK_HZ = 200_000;

    typedef logic [SYM_BITS-1:0] sym_t;

endpackage : dqpsk_pkg

// File: rtl/sym_phase_cnt.sv
// Mod-WIDTH symbol phase counter; load strobe marks phase 0 of each symbol.
module sym_phase_cnt #(
    parameter int WIDTH = 2,
    parameter int CW    = (WIDTH > 1) ? $clog2(WIDTH) : 1
) (
    input  logic          clk_in,
    input  logic          rstn,
    output logic [CW-1:0] cnt,
    output logic          load
);

    logic [CW-1:0] cnt_reg;
    logic [CW-1:0] cnt_next;

    always_comb begin
        cnt_next = cnt_reg + CW'(1);
        if (cnt_reg == CW'(WIDTH - 1)) begin
            cnt_next = '0;
        end
    end

    // rstn is active-high despite its name.
    always_ff @(posedge clk_in or posedge rstn) begin
        if (rstn) begin
            cnt_reg <= '0;
        end else begin
            cnt_reg <= cnt_next;
        end
    end

    assign cnt  = cnt_reg;
    assign load = (cnt_reg == '0);

endmodule : sym_phase_cnt

// File: rtl/par_to_ser.sv
// DQPSK transmit parallel-to-serial converter: one symbol per WIDTH bit clocks, MSB first.
module par_to_ser
    import dqpsk_pkg::*;
#(
    parameter int WIDTH = SYM_BITS
) (
    input  logic             clk_in,
    input  logic             rstn,
    input  logic [WIDTH-1:0] data_par,
    output logic             data_ser,
    output logic             par2ser_valid
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    logic [CW-1:0]    cnt;
    logic             load;
    logic [CW-1:0]    bit_idx;
    logic [WIDTH-1:0] shreg_reg;
    logic             data_ser_reg;
    logic             valid_reg;

    sym_phase_cnt #(
        .WIDTH (WIDTH),
        .CW    (CW)
    ) u_phase (
        .clk_in (clk_in),
        .rstn   (rstn),
        .cnt    (cnt),
        .load   (load)
    );

    // Shift phase k emits bit WIDTH-1-k of the captured symbol; shreg is never shifted.
    assign bit_idx = CW'(WIDTH - 1) - cnt;

    always_ff @(posedge clk_in or posedge rstn) begin
        if (rstn) begin
            shreg_reg    <= '0;
            data_ser_reg <= 1'b0;
            valid_reg    <= 1'b0;
        end else if (load) begin
            shreg_reg    <= data_par;
            data_ser_reg <= data_par[WIDTH-1];
            valid_reg    <= 1'b1;
        end else begin
            data_ser_reg <= shreg_reg[bit_idx];
        end
    end

    assign data_ser      = data_ser_reg;
    assign par2ser_valid = valid_reg;

endmodule : par_to_ser

// File: tb/tb_par_to_ser.sv
// Directed bench for par_to_ser (WIDTH=2): reset, streaming, decimation, mid-symbol reset, random run.
module tb_par_to_ser;
    import dqpsk_pkg::*;

    logic clk_in = 1'b0;
    logic rstn;
    sym_t data_par;
    logic data_ser;
    logic par2ser_valid;

    int errors = 0;
    int checks = 0;

    par_to_ser #(.WIDTH(SYM_BITS)) dut (
        .clk_in        (clk_in),
        .rstn          (rstn),
        .data_par      (data_par),
        .data_ser      (data_ser),
        .par2ser_valid (par2ser_valid)
    );

    always #5 clk_in = ~clk_in;

    task automatic step();
        @(posedge clk_in);
        #1;
    endtask

    task automatic check(input string tag, input logic observed, input logic expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("FAIL %s: observed=%b expected=%b", tag, observed, expected);
        end
    endtask

    initial begin
        logic exp_bits [8];
        sym_t dec_seq  [8];
        sym_t sym;
        sym_t junk;

        // Reset held for 3 cycles with data_par=11
        rstn     = 1'b1;
        data_par = 2'b11;
        for (int i = 0; i < 3; i++) begin
            step();
            check("rst_ser", data_ser, 1'b0);
            check("rst_valid", par2ser_valid, 1'b0);
        end
        rstn = 1'b0;
        #1;
        check("rel_ser", data_ser, 1'b0);
        check("rel_valid", par2ser_valid, 1'b0);

        // Basic stream 10,11,01,00
        exp_bits = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
        dec_seq  = '{2'b10, 2'b10, 2'b11, 2'b11, 2'b01, 2'b01, 2'b00, 2'b00};
        for (int i = 0; i < 8; i++) begin
            data_par = dec_seq[i];
            step();
            check($sformatf("basic_ser[%0d]", i), data_ser, exp_bits[i]);
            check($sformatf("basic_valid[%0d]", i), par2ser_valid, 1'b1);
        end

        // Decimation: data_par changes every cycle, only load-edge values captured
        exp_bits = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1};
        dec_seq  = '{2'b10, 2'b10, 2'b11, 2'b01, 2'b10, 2'b00, 2'b11, 2'b11};
        for (int i = 0; i < 8; i++) begin
            data_par = dec_seq[i];
            step();
            check($sformatf("decim_ser[%0d]", i), data_ser, exp_bits[i]);
        end

        // Mid-symbol reset after MSB of 10
        data_par = 2'b10;
        step();
        check("mid_msb", data_ser, 1'b1);
        rstn = 1'b1;
        #1;
        check("mid_async_ser", data_ser, 1'b0);
        check("mid_async_valid", par2ser_valid, 1'b0);
        data_par = 2'b01;
        step();
        check("mid_hold_ser", data_ser, 1'b0);
        rstn = 1'b0;
        step();
        check("mid_new_msb", data_ser, 1'b0);
        check("mid_new_valid", par2ser_valid, 1'b1);
        step();
        check("mid_new_lsb", data_ser, 1'b1);

        // Stability: data_par toggled on the shift edge is ignored
        data_par = 2'b11;
        step();
        check("stab_msb", data_ser, 1'b1);
        data_par = 2'b00;
        step();
        check("stab_lsb", data_ser, 1'b1);
        step();
        check("stab_next_msb", data_ser, 1'b0);
        step();
        check("stab_next_lsb", data_ser, 1'b0);

        // 100 random symbols with junk driven on shift edges
        for (int s = 0; s < 100; s++) begin
            sym      = sym_t'($urandom_range(0, 3));
            data_par = sym;
            step();
            check($sformatf("rand_msb[%0d]", s), data_ser, sym[1]);
            check($sformatf("rand_valid_a[%0d]", s), par2ser_valid, 1'b1);
            junk     = sym_t'($urandom_range(0, 3));
            data_par = junk;
            step();
            check($sformatf("rand_lsb[%0d]", s), data_ser, sym[0]);
            check($sformatf("rand_valid_b[%0d]", s), par2ser_valid, 1'b1);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule : tb_par_to_ser
